// File: rtl/alarm_ring_ctrl.sv
// Alarm ring controller: match detect, timed ring, optional snooze, buzzer tone.
// Optional snooze feature enabled by defining ALARM_SNOOZE_EN.
module alarm_ring_ctrl #(
    parameter int RING_SECONDS   = 60,
    parameter int SNOOZE_SECONDS = 300,
    parameter int MAX_SNOOZE     = 3,
    parameter int BEEP_DIV       = 25000
) (
    input  logic       clk_50M,
    input  logic       rst_n,
    input  logic       sec_tick,
    input  logic [3:0] state_mode,
    input  logic       alarm_en,
    input  logic [7:0] cur_hour,
    input  logic [7:0] cur_minute,
    input  logic [7:0] cur_second,
    input  logic [7:0] alarm_hour,
    input  logic [7:0] alarm_minute,
    input  logic       stop_key,
    input  logic       snooze_key,
    output logic       buzzer,
    output logic       ringing,
    output logic       snoozing
);

    localparam int RW = (RING_SECONDS > 1) ? $clog2(RING_SECONDS + 1) : 1;
    localparam int BW = (BEEP_DIV > 1) ? $clog2(BEEP_DIV) : 1;

    localparam logic [RW-1:0] RING_LAST = RW'(RING_SECONDS - 1);
    localparam logic [BW-1:0] BEEP_LAST = BW'(BEEP_DIV - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RING = 2'd1;

    logic [1:0]    state;
    logic [1:0]    state_nx;
    logic [RW-1:0] ring_cnt;
    logic [RW-1:0] ring_cnt_nx;
    logic [BW-1:0] beep_cnt;
    logic          stop_b0;
    logic          stop_b1;
    logic          stop_press;
    logic          match;
    logic          ring_done;

`ifdef ALARM_SNOOZE_EN
    localparam int SW = (SNOOZE_SECONDS > 1) ? $clog2(SNOOZE_SECONDS + 1) : 1;
    localparam int NW = (MAX_SNOOZE > 0) ? $clog2(MAX_SNOOZE + 1) : 1;

    localparam logic [SW-1:0] SNZ_LOAD = SW'(SNOOZE_SECONDS);
    localparam logic [NW-1:0] SNZ_MAX  = NW'(MAX_SNOOZE);

    localparam logic [1:0] SNOOZE = 2'd2;

    logic [SW-1:0] snz_cnt;
    logic [SW-1:0] snz_cnt_nx;
    logic [NW-1:0] snooze_num;
    logic [NW-1:0] snooze_num_nx;
    logic          snz_b0;
    logic          snz_b1;
    logic          snz_press;

    assign snz_press = snz_b1 & ~snz_b0;

    // Snooze button synchroniser / falling-edge buffer
    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            snz_b0 <= 1'b1;
            snz_b1 <= 1'b1;
        end else begin
            snz_b0 <= snooze_key;
            snz_b1 <= snz_b0;
        end
    end
`else
    logic unused_snooze_key;

    assign unused_snooze_key = snooze_key;
    assign snoozing          = 1'b0;
`endif

    assign stop_press = stop_b1 & ~stop_b0;

    assign match = sec_tick & alarm_en
                 & (state_mode != 4'd3)
                 & (cur_hour == alarm_hour)
                 & (cur_minute == alarm_minute)
                 & (cur_second == 8'd0);

    assign ring_done = sec_tick & (ring_cnt == RING_LAST);

    // Stop button synchroniser / falling-edge buffer
    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            stop_b0 <= 1'b1;
            stop_b1 <= 1'b1;
        end else begin
            stop_b0 <= stop_key;
            stop_b1 <= stop_b0;
        end
    end

    // Next-state and counter update, priority: enable > stop > timeout > snooze
    always_comb begin
        state_nx    = state;
        ring_cnt_nx = ring_cnt;
`ifdef ALARM_SNOOZE_EN
        snz_cnt_nx    = snz_cnt;
        snooze_num_nx = snooze_num;
`endif
        unique case (1'b1)
            (state == IDLE): begin
                if (match) begin
                    state_nx    = RING;
                    ring_cnt_nx = '0;
`ifdef ALARM_SNOOZE_EN
                    snooze_num_nx = '0;
`endif
                end
            end
            (state == RING): begin
                if (!alarm_en || stop_press || ring_done) begin
                    state_nx = IDLE;
`ifdef ALARM_SNOOZE_EN
                end else if (snz_press) begin
                    if (snooze_num < SNZ_MAX) begin
                        state_nx      = SNOOZE;
                        snz_cnt_nx    = SNZ_LOAD;
                        snooze_num_nx = snooze_num + 1'b1;
                    end else begin
                        state_nx = IDLE;
                    end
`endif
                end else if (sec_tick) begin
                    ring_cnt_nx = ring_cnt + 1'b1;
                end
            end
`ifdef ALARM_SNOOZE_EN
            (state == SNOOZE): begin
                if (!alarm_en || stop_press) begin
                    state_nx = IDLE;
                end else if (sec_tick) begin
                    if (snz_cnt <= SW'(1)) begin
                        state_nx    = RING;
                        ring_cnt_nx = '0;
                        snz_cnt_nx  = '0;
                    end else begin
                        snz_cnt_nx = snz_cnt - 1'b1;
                    end
                end
            end
`endif
            default: begin
                state_nx = IDLE;
            end
        endcase
        if (state_nx == IDLE) begin
            ring_cnt_nx = '0;
`ifdef ALARM_SNOOZE_EN
            snz_cnt_nx = '0;
`endif
        end
    end

    // State, counters and status flags
    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ring_cnt <= '0;
            ringing  <= 1'b0;
        end else begin
            state    <= state_nx;
            ring_cnt <= ring_cnt_nx;
            ringing  <= (state_nx == RING);
        end
    end

`ifdef ALARM_SNOOZE_EN
    // Snooze counters and flag
    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            snz_cnt    <= '0;
            snooze_num <= '0;
            snoozing   <= 1'b0;
        end else begin
            snz_cnt    <= snz_cnt_nx;
            snooze_num <= snooze_num_nx;
            snoozing   <= (state_nx == SNOOZE);
        end
    end
`endif

    // Tone divider runs only while staying in RING; silent and cleared otherwise
    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            beep_cnt <= '0;
            buzzer   <= 1'b0;
        end else if (state == RING && state_nx == RING) begin
            if (beep_cnt == BEEP_LAST) begin
                beep_cnt <= '0;
                buzzer   <= ~buzzer;
            end else begin
                beep_cnt <= beep_cnt + 1'b1;
            end
        end else begin
            beep_cnt <= '0;
            buzzer   <= 1'b0;
        end
    end

endmodule

// File: doc/alarm_ring_ctrl.md
ALARM_RING_CTRL -- requirements
Module: alarm_ring_ctrl

Interface
REQ-001 Parameter: RING_SECONDS, 60, ring duration in sec_tick pulses before auto-stop.
REQ-002 Parameter: SNOOZE_SECONDS, 300, snooze interval in sec_tick pulses.
REQ-003 Parameter: MAX_SNOOZE, 3, snoozes allowed per alarm event.
REQ-004 Parameter: BEEP_DIV, 25000, clk_50M cycles per buzzer half-period (1 kHz tone).
REQ-005 Port: clk_50M  in  1  single system clock; all logic on its rising edge.
REQ-006 Port: rst_n  in  1  asynchronous active-low reset.
REQ-007 Port: sec_tick  in  1  one-cycle pulse once per second.
REQ-008 Port: state_mode  in  4  display/edit mode; 4'd3 = alarm-set mode.
REQ-009 Port: alarm_en  in  1  alarm armed (level).
REQ-010 Port: cur_hour / cur_minute / cur_second  in  8 each  current time, binary 0-23 / 0-59 / 0-59.
REQ-011 Port: alarm_hour / alarm_minute  in  8 each  alarm time, binary.
REQ-012 Port: stop_key / snooze_key  in  1 each  active-low push buttons, idle high.
REQ-013 Port: buzzer  out  1  square-wave tone drive.
REQ-014 Port: ringing / snoozing  out  1 each  registered state flags.

Function
REQ-015 Each key SHALL pass a two-flop buffer; press = falling edge (buf1 high, buf0 low), one-cycle pulse, 2 clocks after pin falls.
REQ-016 FSM states SHALL be IDLE, RING, SNOOZE; state and all outputs registered.
REQ-017 IDLE->RING SHALL occur on the edge where sec_tick=1, alarm_en=1, state_mode!=4'd3, cur_hour==alarm_hour, cur_minute==alarm_minute, cur_second==0; ring_cnt and snooze_num cleared to 0.
REQ-018 RING: ring_cnt SHALL increment per sec_tick; reaching RING_SECONDS SHALL return to IDLE.
REQ-019 RING: stop press SHALL return to IDLE next edge.
REQ-020 RING: snooze press with snooze_num<MAX_SNOOZE SHALL enter SNOOZE, load snz_cnt=SNOOZE_SECONDS, increment snooze_num; with snooze_num==MAX_SNOOZE SHALL act as stop.
REQ-021 SNOOZE: snz_cnt SHALL decrement per sec_tick; transition 1->0 SHALL enter RING with ring_cnt=0 (snooze_num retained).
REQ-022 SNOOZE: stop press SHALL return to IDLE; snooze press SHALL be ignored.
REQ-023 alarm_en=0 in RING or SNOOZE SHALL force IDLE next edge (highest priority after reset).
REQ-024 Simultaneous events priority: alarm_en low > stop > timeout > snooze; stop+snooze same cycle = stop.
REQ-025 Match condition in RING/SNOOZE SHALL be ignored; state_mode==3 SHALL NOT abort an active ring.
REQ-026 buzzer SHALL toggle every BEEP_DIV cycles only in RING, 0 elsewhere; divider cleared when not in RING.
REQ-027 ringing=1 iff state RING; snoozing=1 iff state SNOOZE.
REQ-028 Counters SHALL be sized for their parameter maxima; no wrap-around beyond limits.

Reset
REQ-029 rst_n low SHALL immediately force state IDLE, buzzer/ringing/snoozing 0, all counters 0, key buffers 1.
REQ-030 Reset mid-RING or mid-SNOOZE SHALL abandon the event; no re-ring until next match after release.

Configuration
REQ-031 Macro ALARM_SNOOZE_EN: defined -> SNOOZE state and snooze logic present per REQ-020..022; undefined -> snooze_key ignored, snoozing tied 0, SNOOZE state and snz_cnt absent.

Verification
REQ-032 Alarm 06:30, time 06:29:59->06:30:00 with sec_tick, alarm_en=1 -> ringing=1 next edge, buzzer toggling every 25000 cycles.
REQ-033 Ring untouched 60 sec_ticks -> ringing=0 after 60th tick, buzzer=0.
REQ-034 Snooze press during RING -> snoozing=1; 300 sec_ticks later ringing=1; repeat 3 snoozes, 4th snooze press -> IDLE.
REQ-035 stop and snooze pressed same cycle in RING -> IDLE, snoozing=0.
REQ-036 state_mode=3 at match time -> no ring; alarm_en dropped mid-SNOOZE -> IDLE next edge.
REQ-037 rst_n asserted mid-RING -> outputs 0 immediately; without ALARM_SNOOZE_EN snooze press keeps ringing=1.
